prng_seq_ctrl: RTL
==================

# prng_seq_ctrl

Sequencer for the seed-to-random-number datapath. It accepts one 32-bit seed per job and drives an xorshift32 generator that produces exactly NUM_OUT words. The words are buffered in a small output FIFO so the generator can run ahead of a slow or back-pressuring consumer, such as the clock-domain handshake toward the output domain. The block sits in the generator clock domain, between the seed synchronizer and the output synchronizer.

## Interface
- NUM_OUT, 256, number of words generated per seed (≥1)
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

- clk  input  1  block clock
- rst  input  1  synchronous reset, active-high
- seed_valid  input  1  seed offered
- seed  input  32  seed value
- seed_ready  output  1  seed accepted when seed_valid && seed_ready
- out_valid  output  1  FIFO head valid
- out_data  output  32  FIFO head word
- out_ready  input  1  consumer takes head when out_valid && out_ready
- busy  output  1  job in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse, job complete

## Operation
- xs(x) = x ^= x<<13; x ^= x>>17; x ^= x<<5, all 32-bit and truncating.
- Internal state:
  - x: 32-bit generator register.
  - gen_cnt: counts 0..NUM_OUT, width $clog2(NUM_OUT+1).
  - FIFO: rd/wr pointers plus an occupancy count 0..FIFO_DEPTH.
- FSM states: IDLE, GEN, DRAIN.
  - IDLE: seed_ready=1. On seed accept: x←seed, gen_cnt←0, go to GEN.
  - GEN: push = (count<FIFO_DEPTH) || pop. On push: FIFO←xs(x), x←xs(x), gen_cnt+1. Once the push that makes gen_cnt=NUM_OUT occurs, go to DRAIN.
  - DRAIN: no pushes. When the pop that empties the FIFO occurs, go to IDLE and pulse done.
- pop = out_valid && out_ready. out_valid = (count≠0). out_data = entry at rd pointer.
- Push and pop in the same cycle:
  - Count is unchanged.
  - Push is allowed while the FIFO is full.
  - A push into an empty FIFO does not bypass to the output; the word appears on out_data the next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- seed_valid outside IDLE is ignored, and seed_ready=0 there.
- No word is ever lost, duplicated or reordered. Output order is xs¹(seed), xs²(seed), …, xs^NUM_OUT(seed).

## Timing
- Reset values: seed_ready=1, out_valid=0, out_data=0, busy=0, done=0. State=IDLE, x=0, gen_cnt=0, FIFO empty.
- Reset mid-job aborts immediately. All outputs take reset values on the next edge, and FIFO contents are discarded.
- Seed accepted at edge E0:
  - first push at E1;
  - out_valid=1 after E1;
  - first-word latency is 2 cycles.
- With out_ready held high, throughput is one word per cycle after the first word.
- A full job with no backpressure takes NUM_OUT+2 cycles from seed accept to done.
- done is registered. It is high in the cycle after the edge that popped the last word; in that same cycle state=IDLE, seed_ready=1 and busy=0.
- A new seed may be accepted in the done cycle.
- busy rises the cycle after the seed is accepted.

## Configuration
- ZERO_SEED_FIX_EN defined: an accepted seed of 32'h0 loads x←32'h0000_0001, so a zero seed gives the same output stream as seed 1.
- ZERO_SEED_FIX_EN undefined: seed 0 is loaded as-is and the job emits NUM_OUT words of 32'h0, with normal handshake and done behaviour.

## Test plan
- Seed 32'h1, out_ready=1, NUM_OUT=256:
  - first word 32'h00042021, appearing 2 cycles after accept;
  - 256 consecutive words matching the reference model;
  - done exactly at cycle 258.
- out_ready=0 for 20 cycles after accept: the FIFO fills to 4, gen_cnt stalls at 4, out_valid stays 1 with out_data=32'h00042021 (seed 1). On release the stream continues with no gap or duplicate.
- Random out_ready toggling over 3 back-to-back seeds:
  - each job outputs exactly NUM_OUT words in order;
  - the second seed is accepted in the first job's done cycle;
  - seeds offered while busy are not consumed.
- Reset during GEN, with the FIFO holding 3 words and gen_cnt=100: next cycle out_valid=0, busy=0, seed_ready=1, and no done pulse. A new seed then runs a clean job.
- Seed 32'h0:
  - with ZERO_SEED_FIX_EN, the first word is 32'h00042021;
  - without it, all NUM_OUT words are 0 and done still pulses once.
- NUM_OUT=1 and FIFO_DEPTH=2 boundary:
  - one word, then DRAIN, then done;
  - out_ready held 0 keeps the job in DRAIN and holds done low until the word is popped.

Source files
------------

// File: rtl/prng_seq_ctrl.sv
// prng_seq_ctrl: accepts one 32-bit seed per job, runs an xorshift32
// generator for NUM_OUT steps and buffers the words in a small FIFO.
// The generator can run ahead of a back-pressuring consumer.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. Valid never depends on ready. seed_ready is high only in
// IDLE. out_valid means the FIFO is not empty.
//
// Build option: define ZERO_SEED_FIX_EN to replace an accepted seed of 0
// with 1. Otherwise a zero seed gives a stream of zero words.
module prng_seq_ctrl #(
  parameter int NUM_OUT    = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  input  logic [31:0] seed,
  output logic        seed_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int GW = $clog2(NUM_OUT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [GW-1:0] GEN_LAST = GW'(NUM_OUT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     x_q, x_d;
  logic [GW-1:0]   gen_cnt_q, gen_cnt_d;
  logic            done_q, done_d;

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;

  logic            push;
  logic            pop;
  logic [31:0]     x_next;
  logic [31:0]     seed_load;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  assign x_next = xs(x_q);
  assign pop    = (count_q != '0) && out_ready;

`ifdef ZERO_SEED_FIX_EN
  // A zero seed would lock xorshift at zero; substitute 1.
  assign seed_load = (seed == 32'h0) ? 32'h0000_0001 : seed;
`else
  assign seed_load = seed;
`endif

  // Next-state logic for the job FSM, generator and job counter.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    gen_cnt_d  = gen_cnt_q;
    push       = 1'b0;
    done_d     = 1'b0;
    seed_ready = 1'b0;
    case (state_q)
      IDLE: begin
        seed_ready = 1'b1;
        if (seed_valid) begin
          x_d       = seed_load;
          gen_cnt_d = '0;
          state_d   = GEN;
        end
      end
      GEN: begin
        // A full FIFO still accepts a push when the head leaves this cycle.
        push = (count_q < CNT_FULL) || pop;
        if (push) begin
          x_d       = x_next;
          gen_cnt_d = gen_cnt_q + GW'(1);
          if (gen_cnt_q == GEN_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (count_q == CNT_ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register the FSM state, generator, job counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      gen_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      gen_cnt_q <= gen_cnt_d;
      done_q    <= done_d;
    end
  end

  // Output FIFO: pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= x_next;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
